cam_reset_seq: RTL
==================

// Module: cam_reset_seq
// PURPOSE
// - Power-up/reset sequencer for the MIPI camera sensor's active-low reset line (mipi_rst).
// - Sits upstream of the mipi_rst IOBUF: its o/t outputs drive IOBUF .I/.T.
// - Holds the sensor in reset until the 25 MHz sensor clock (clk_wiz locked) is stable, then releases it.
// - Raises cam_ready once the sensor settle time has elapsed; this gates I2C sensor configuration.
// PARAMETERS
// - AUTO_START        1          1: start the sequence automatically after reset; 0: wait for start.
// - RST_LOW_CYC       50000      clk_50m cycles reset is held low after lock is seen (1 ms).
// - SETTLE_CYC        1000000    clk_50m cycles from reset release to cam_ready (20 ms).
// - LOCK_TIMEOUT_CYC  5000000    max cycles spent in WAIT_LOCK before error (100 ms).
// - RELEASE_HIZ       0          1: released line is tri-stated (t=1, external pull-up); 0: driven high.
// PORTS
// - Clocking: one clock; reset is synchronous and active-high.
// - clk_50m      in   1  system clock; all logic on rising edge.
// - reset        in   1  synchronous, active-high.
// - clk_locked   in   1  clk_wiz locked; asynchronous, synchronised internally.
// - start        in   1  1-cycle pulse: (re)run the sequence; honoured only in IDLE/READY/ERROR.
// - cam_rst_o    out  1  IOBUF .I for mipi_rst.
// - cam_rst_t    out  1  IOBUF .T for mipi_rst (1 = high-Z).
// - cam_ready    out  1  level; sensor out of reset and settled.
// - seq_busy     out  1  high in WAIT_LOCK/HOLD_RST/SETTLE.
// - lock_err     out  1  sticky; lock timeout occurred; cleared on accepted start or reset.
// - state_dbg    out  3  current state encoding, for VIO/ILA.
// BEHAVIOUR
// - States: IDLE=0, WAIT_LOCK=1, HOLD_RST=2, SETTLE=3, READY=4, ERROR=5.
// - Reset: state=IDLE, cam_rst_o=0, cam_rst_t=0 (sensor held in reset), cam_ready=0, seq_busy=0, lock_err=0; counter=0; sync FFs=0.
// - clk_locked passes a 2-FF synchroniser (locked_s); 2-cycle latency.
// - IDLE -> WAIT_LOCK: on the first cycle after reset if AUTO_START=1, otherwise on start.
// - WAIT_LOCK: line driven low; counter increments.
//   - locked_s=1 -> HOLD_RST, counter cleared.
//   - counter reaches LOCK_TIMEOUT_CYC-1 without lock -> ERROR, lock_err=1.
// - HOLD_RST: line driven low for exactly RST_LOW_CYC cycles, then SETTLE with counter cleared.
// - SETTLE: line released (o=1,t=0, or o=0,t=1 if RELEASE_HIZ); after exactly SETTLE_CYC cycles -> READY.
// - READY: cam_ready=1, line stays released.
// - ERROR: line driven low; cam_ready=0.
// - start in READY/ERROR -> WAIT_LOCK: lock_err cleared and line driven low. Ignored while seq_busy.
// - locked_s falls in HOLD_RST/SETTLE/READY -> WAIT_LOCK: line re-asserted low, cam_ready drops, counter cleared.
// - If lock loss and start coincide, both resolve to WAIT_LOCK; lock_err stays 0.
// - Outputs are registered and decoded from next-state: they change on the same edge as the state.
// - Counter width = $clog2(max of the three *_CYC)+1; no wrap is possible because the counter is cleared on every transition.
// - reset asserted mid-sequence -> immediate return to reset values; the line is driven low.
// STRUCTURE
// - Include cam_seq_defs.vh holds: state localparams (S_IDLE..S_ERROR), STATE_W=3.
// - Sub-module sync_2ff (1-bit, 2-stage) for clk_locked; reused for other async GPIO inputs.
// - Single FSM always block plus one shared down/up counter; no other sub-modules.
// TESTING (bench overrides RST_LOW_CYC=8, SETTLE_CYC=16, LOCK_TIMEOUT_CYC=32)
// 1. AUTO_START=1, clk_locked=1 from the start -> cam_rst_o low exactly 8 cycles after HOLD_RST entry; cam_ready rises 16 cycles after release.
// 2. clk_locked held 0 -> lock_err=1 and state_dbg=5 after 32 WAIT_LOCK cycles; cam_rst_o=0, t=0 throughout.
// 3. From ERROR: set clk_locked=1, pulse start -> lock_err clears next edge; READY reached with the same 8/16 timing.
// 4. In READY, drop clk_locked for 1 cycle -> within 3 cycles cam_ready=0, line driven low, full sequence reruns.
// 5. Pulse start during SETTLE -> ignored; READY timing unchanged; reset pulse in SETTLE -> all outputs return to reset values on the next edge.
// 6. RELEASE_HIZ=1 -> SETTLE/READY show cam_rst_t=1; AUTO_START=0 -> stays IDLE until start.

Source files
------------

// File: rtl/cam_reset_seq_pkg.sv
// Shared types and helpers for the MIPI camera reset sequencer.
// State encodings are fixed because state_dbg is read by VIO/ILA probes.
package cam_reset_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_HOLD_RST  = 3'd2,
    S_SETTLE    = 3'd3,
    S_READY     = 3'd4,
    S_ERROR     = 3'd5
  } cam_state_e;

  typedef struct packed {
    logic rst_o;
    logic rst_t;
    logic ready;
    logic busy;
  } cam_out_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

  // The line is released only in SETTLE/READY; every other state holds the sensor in reset.
  function automatic cam_out_t decode_outputs(input cam_state_e s, input logic release_hiz);
    cam_out_t o;
    o = '0;
    if (s == S_SETTLE || s == S_READY) begin
      o.rst_o = ~release_hiz;
      o.rst_t = release_hiz;
    end
    o.ready = (s == S_READY);
    o.busy  = (s == S_WAIT_LOCK) || (s == S_HOLD_RST) || (s == S_SETTLE);
    return o;
  endfunction

endpackage

// File: rtl/cam_reset_seq_if.sv
// Control/status bundle between the camera reset sequencer and its surroundings.
interface cam_reset_seq_if;
  import cam_reset_seq_pkg::*;

  // clk_locked is asynchronous (synchronised inside the sequencer); start is a 1-cycle
  // pulse with no acknowledge, honoured only when seq_busy is low, otherwise dropped.
  logic               clk_locked;
  logic               start;
  logic               cam_rst_o;
  logic               cam_rst_t;
  logic               cam_ready;
  logic               seq_busy;
  logic               lock_err;
  logic [STATE_W-1:0] state_dbg;

  modport master (
    input  clk_locked,
    input  start,
    output cam_rst_o,
    output cam_rst_t,
    output cam_ready,
    output seq_busy,
    output lock_err,
    output state_dbg
  );

  modport slave (
    output clk_locked,
    output start,
    input  cam_rst_o,
    input  cam_rst_t,
    input  cam_ready,
    input  seq_busy,
    input  lock_err,
    input  state_dbg
  );

endinterface

// File: rtl/cam_reset_seq_sync_2ff.sv
// Two-stage synchroniser for a single asynchronous level input (clk_locked, GPIOs).
module cam_reset_seq_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/cam_reset_seq.sv
// Power-up sequencer for the MIPI sensor's active-low reset line: hold low until the
// sensor clock is locked, release, then flag cam_ready after the settle time.
module cam_reset_seq
  import cam_reset_seq_pkg::*;
#(
  parameter int AUTO_START       = 1,
  parameter int RST_LOW_CYC      = 50000,
  parameter int SETTLE_CYC       = 1000000,
  parameter int LOCK_TIMEOUT_CYC = 5000000,
  parameter int RELEASE_HIZ      = 0
) (
  input logic             clk_50m,
  input logic             reset,
  cam_reset_seq_if.master bus
);

  localparam int CNT_MAX = max3(RST_LOW_CYC, SETTLE_CYC, LOCK_TIMEOUT_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  logic       locked_s;
  cam_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       start_ok;
  cam_out_t   out_q, out_d;

  cam_reset_seq_sync_2ff u_lock_sync (
    .clk (clk_50m),
    .rst (reset),
    .d   (bus.clk_locked),
    .q   (locked_s)
  );

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((AUTO_START != 0) || bus.start) begin
          state_d  = S_WAIT_LOCK;
          start_ok = 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s)                state_d = S_HOLD_RST;
        else if (cnt_q == LOCK_LAST) state_d = S_ERROR;
      end
      // Lock loss takes priority over count completion: the sensor clock is no longer trusted.
      S_HOLD_RST: begin
        if (!locked_s)               state_d = S_WAIT_LOCK;
        else if (cnt_q == HOLD_LAST) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!locked_s)                 state_d = S_WAIT_LOCK;
        else if (cnt_q == SETTLE_LAST) state_d = S_READY;
      end
      S_READY: begin
        if (!locked_s || bus.start) begin
          state_d  = S_WAIT_LOCK;
          start_ok = bus.start;
        end
      end
      S_ERROR: begin
        if (bus.start) begin
          state_d  = S_WAIT_LOCK;
          start_ok = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // One shared counter; clearing it on every state change keeps it from ever wrapping.
  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == S_WAIT_LOCK || state_q == S_HOLD_RST || state_q == S_SETTLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (start_ok) err_d = 1'b0;
    if (state_d == S_ERROR && state_q != S_ERROR) err_d = 1'b1;
    out_d = decode_outputs(state_d, RELEASE_HIZ != 0);
  end

  always_ff @(posedge clk_50m) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  assign bus.cam_rst_o = out_q.rst_o;
  assign bus.cam_rst_t = out_q.rst_t;
  assign bus.cam_ready = out_q.ready;
  assign bus.seq_busy  = out_q.busy;
  assign bus.lock_err  = err_q;
  assign bus.state_dbg = state_q;

endmodule
